// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants and state encoding for the switch event encoder
package sw_pkg;

    typedef enum logic {
        PRIO_LOW  = 1'b0,
        PRIO_HIGH = 1'b1
    } prio_e;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    // Wide enough for the largest legal stability count (255)
    localparam int CNT_W = 8;

endpackage

// File: rtl/sw_event_encoder_if.sv
// rtl/sw_event_encoder_if.sv - switch inputs and event outputs of the switch event encoder
interface sw_event_encoder_if #(
    parameter int N_SW  = 8,
    parameter int IDX_W = $clog2(N_SW)
);
    logic [N_SW-1:0]  sw;
    logic             clear;
    logic [IDX_W-1:0] bin_value;
    logic             valid;
    logic             new_evt;
    logic [N_SW-1:0]  db_sw;

    modport master (
        output sw,
        output clear,
        input  bin_value,
        input  valid,
        input  new_evt,
        input  db_sw
    );

    modport slave (
        input  sw,
        input  clear,
        output bin_value,
        output valid,
        output new_evt,
        output db_sw
    );
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one switch channel: two-flop synchroniser, stability counter, debounced bit
module sw_debounce
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The bit flips on the mismatch edge that finds the counter already at DB_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_event_encoder.sv
// rtl/sw_event_encoder.sv - debounces N_SW switches and encodes the latest rising switch as an index
module sw_event_encoder
    import sw_pkg::*;
#(
    parameter int    N_SW      = 8,
    parameter int    DB_CYCLES = 4,
    parameter prio_e PRIO_MODE = PRIO_LOW
) (
    input  logic               clk,
    input  logic               rst_n,
    sw_event_encoder_if.slave  bus
);

    localparam int IDX_W = $clog2(N_SW);

    logic [N_SW-1:0]  db;
    logic [N_SW-1:0]  db_d;
    logic [N_SW-1:0]  rise;
    logic [IDX_W-1:0] winner;
    state_e           state;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        sw_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .sw   (bus.sw[i]),
            .db   (db[i])
        );
    end

    assign bus.db_sw = db;
    assign rise      = db & ~db_d;

    // Scan order makes the last hit the preferred index
    always_comb begin
        winner = '0;
        if (PRIO_MODE == PRIO_HIGH) begin
            for (int k = 0; k < N_SW; k++) begin
                if (rise[k]) winner = IDX_W'(k);
            end
        end else begin
            for (int k = N_SW - 1; k >= 0; k--) begin
                if (rise[k]) winner = IDX_W'(k);
            end
        end
    end

    // A rise always takes precedence over clear; bin_value is left alone when emptied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            db_d          <= '0;
            bus.bin_value <= '0;
            bus.valid     <= 1'b0;
            bus.new_evt   <= 1'b0;
        end else begin
            db_d        <= db;
            bus.new_evt <= 1'b0;
            case (state)
                EMPTY: begin
                    if (|rise) begin
                        state         <= HELD;
                        bus.bin_value <= winner;
                        bus.valid     <= 1'b1;
                        bus.new_evt   <= 1'b1;
                    end
                end
                HELD: begin
                    if (|rise) begin
                        bus.bin_value <= winner;
                        bus.valid     <= 1'b1;
                        bus.new_evt   <= 1'b1;
                    end else if (bus.clear) begin
                        state     <= EMPTY;
                        bus.valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_event_encoder.sv
// tb/tb_sw_event_encoder.sv - directed and randomized checks of sw_event_encoder against a sample-window model
module tb_sw_event_encoder;
    import sw_pkg::*;

    localparam int DB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sw_event_encoder_if #(.N_SW(8))  bus0 ();
    sw_event_encoder_if #(.N_SW(8))  bus1 ();
    sw_event_encoder_if #(.N_SW(16)) bus2 ();

    assign bus1.sw    = bus0.sw;
    assign bus1.clear = bus0.clear;

    sw_event_encoder #(.N_SW(8), .DB_CYCLES(DB), .PRIO_MODE(PRIO_LOW)) dut_lo (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    sw_event_encoder #(.N_SW(8), .DB_CYCLES(DB), .PRIO_MODE(PRIO_HIGH)) dut_hi (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    sw_event_encoder #(.N_SW(16), .DB_CYCLES(1), .PRIO_MODE(PRIO_LOW)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a level is accepted once the DB+1 most recent synchronised samples all disagree with it
    logic [7:0] hist[$];
    logic [7:0] m_db, m_db_d;
    logic [2:0] m_bin_lo, m_bin_hi;
    logic       m_valid, m_new;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < DB + 3; i++) hist.push_back(8'h00);
        m_db = '0; m_db_d = '0; m_bin_lo = '0; m_bin_hi = '0;
        m_valid = 1'b0; m_new = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] s, input logic c);
        logic [7:0] r;
        logic [7:0] all_diff;
        logic [8:0] rp1;
        r = m_db & ~m_db_d;
        hist.push_back(s);
        if (hist.size() > 64) void'(hist.pop_front());
        all_diff = 8'hFF;
        for (int k = 0; k <= DB; k++) all_diff &= hist[hist.size() - 3 - k] ^ m_db;
        m_db_d = m_db;
        m_db   = m_db ^ all_diff;
        m_new  = 1'b0;
        if (r != 8'h00) begin
            m_bin_lo = 3'($clog2(r & (~r + 8'd1)));
            rp1      = {1'b0, r} + 9'd1;
            m_bin_hi = 3'($clog2(rp1) - 1);
            m_valid  = 1'b1;
            m_new    = 1'b1;
        end else if (c) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(bus0.sw, bus0.clear);
        #1;
        check("db_lo",    32'(bus0.db_sw),     32'(m_db));
        check("bin_lo",   32'(bus0.bin_value), 32'(m_bin_lo));
        check("valid_lo", 32'(bus0.valid),     32'(m_valid));
        check("new_lo",   32'(bus0.new_evt),   32'(m_new));
        check("db_hi",    32'(bus1.db_sw),     32'(m_db));
        check("bin_hi",   32'(bus1.bin_value), 32'(m_bin_hi));
        check("valid_hi", 32'(bus1.valid),     32'(m_valid));
        check("new_hi",   32'(bus1.new_evt),   32'(m_new));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_lo", 32'({bus0.db_sw, bus0.bin_value, bus0.valid, bus0.new_evt}), 32'd0);
        check("rst_hi", 32'({bus1.db_sw, bus1.bin_value, bus1.valid, bus1.new_evt}), 32'd0);
        check("rst_w",  32'({bus2.db_sw, bus2.bin_value, bus2.valid, bus2.new_evt}), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_new;
        int   idx;
        bus0.sw = '0; bus0.clear = 1'b0;
        bus2.sw = '0; bus2.clear = 1'b0;
        #1;
        do_reset();

        // Single switch with default parameters
        bus0.sw = 8'b0000_0100;
        for (int e = 0; e <= 8; e++) begin
            tick();
            if (e == 5) check("r29_db_e5", 32'(bus0.db_sw[2]), 32'd0);
            if (e == 6) check("r29_db_e6", 32'(bus0.db_sw[2]), 32'd1);
            if (e == 6) check("r29_new_e6", 32'(bus0.new_evt), 32'd0);
            if (e == 7) check("r29_evt", 32'({bus0.bin_value, bus0.valid, bus0.new_evt}), 32'({3'd2, 2'b11}));
            if (e == 8) check("r29_once", 32'({bus0.valid, bus0.new_evt}), 32'b10);
        end

        // Three-cycle glitch on sw[5]
        seen_new = 1'b0;
        bus0.sw = 8'b0010_0100;
        for (int i = 0; i < 3; i++) begin tick(); seen_new |= bus0.new_evt; end
        bus0.sw = 8'b0000_0100;
        for (int i = 0; i < 10; i++) begin tick(); seen_new |= bus0.new_evt; end
        check("r30_db", 32'(bus0.db_sw), 32'h04);
        check("r30_no_evt", 32'(seen_new), 32'd0);

        // Simultaneous rises, both priority modes
        bus0.sw = '0;
        do_reset();
        bus0.sw = 8'b1001_0010;
        for (int e = 0; e <= 7; e++) tick();
        check("r31_lo", 32'({bus0.bin_value, bus0.new_evt}), 32'({3'd1, 1'b1}));
        check("r31_hi", 32'({bus1.bin_value, bus1.new_evt}), 32'({3'd7, 1'b1}));

        // Clear colliding with a rise, then clear alone, then clear while empty
        bus0.sw = 8'b1101_0010;
        for (int e = 0; e <= 6; e++) tick();
        bus0.clear = 1'b1;
        tick();
        bus0.clear = 1'b0;
        check("r32_collide", 32'({bus0.bin_value, bus0.valid, bus0.new_evt}), 32'({3'd6, 2'b11}));
        for (int i = 0; i < 3; i++) tick();
        bus0.clear = 1'b1;
        tick();
        check("r32_clear_lo", 32'({bus0.bin_value, bus0.valid}), 32'({3'd6, 1'b0}));
        check("r32_clear_hi", 32'({bus1.bin_value, bus1.valid}), 32'({3'd6, 1'b0}));
        tick();
        bus0.clear = 1'b0;
        check("r32_clear_empty", 32'({bus0.bin_value, bus0.valid}), 32'({3'd6, 1'b0}));

        // Reset in the middle of a debounce
        bus0.sw = '0;
        do_reset();
        bus0.sw = 8'b0000_1000;
        for (int e = 0; e <= 3; e++) tick();
        do_reset();
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 6) check("r33_early", 32'(bus0.new_evt), 32'd0);
            if (e == 7) check("r33_evt", 32'({bus0.bin_value, bus0.valid, bus0.new_evt}), 32'({3'd3, 2'b11}));
        end

        // Wide instance with a one-cycle stability requirement
        do_reset();
        bus2.sw = 16'h8000;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e == 3) check("r34_db_e3", 32'({bus2.db_sw[15], bus2.new_evt}), 32'b10);
            if (e == 4) check("r34_evt", 32'({bus2.bin_value, bus2.valid, bus2.new_evt}), 32'({4'hF, 2'b11}));
            if (e == 5) check("r34_once", 32'(bus2.new_evt), 32'd0);
        end
        bus2.sw = '0;

        // Randomized switch activity, clears and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                bus0.sw = 8'($urandom);
            end else if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, 7));
                bus0.sw = bus0.sw ^ (8'd1 << idx);
            end
            bus0.clear = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_event_encoder.md
SW_EVENT_ENCODER -- requirements
Module: sw_event_encoder

Interface
REQ-001 The module SHALL have parameter N_SW, default 8, meaning the number of switch inputs (legal range 2..32).
REQ-002 The module SHALL have parameter DB_CYCLES, default 4, meaning the consecutive stable cycles required to accept a change (legal range 1..255).
REQ-003 The module SHALL have parameter PRIO_MODE, default PRIO_LOW, meaning the winner among simultaneous rises (PRIO_LOW: lowest index; PRIO_HIGH: highest index).
REQ-004 The module SHALL have a derived localparam IDX_W = $clog2(N_SW).
REQ-005 Port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port sw, input, N_SW bits: raw asynchronous switch levels.
REQ-008 Port clear, input, 1 bit: synchronous request to drop the held index.
REQ-009 Port bin_value, output, IDX_W bits: registered index of the last accepted rising switch.
REQ-010 Port valid, output, 1 bit: registered; high while bin_value holds an accepted index.
REQ-011 Port new_evt, output, 1 bit: registered one-cycle pulse when bin_value is loaded.
REQ-012 Port db_sw, output, N_SW bits: registered debounced switch levels.

Function
REQ-013 Each sw bit SHALL pass through a two-flop synchroniser before any other logic.
REQ-014 Each channel SHALL keep a counter that increments while the synchronised bit differs from db_sw and clears to 0 whenever they match.
REQ-015 A db_sw bit SHALL toggle, and its counter SHALL clear, on the edge at which the mismatch has persisted DB_CYCLES consecutive cycles.
REQ-016 A glitch shorter than DB_CYCLES synchronised cycles SHALL NOT change db_sw.
REQ-017 The rise vector SHALL be db_sw AND NOT db_sw delayed one cycle; falls SHALL NOT generate events.
REQ-018 When the rise vector is nonzero, the edge SHALL load bin_value with the priority winner per PRIO_MODE, set valid=1, and assert new_evt for exactly that cycle.
REQ-019 The FSM SHALL have states EMPTY (valid=0) and HELD (valid=1): EMPTY->HELD on rise; HELD->HELD on rise (reload, new_evt); HELD->EMPTY on clear without rise; clear in EMPTY SHALL have no effect.
REQ-020 When clear and rise occur in the same cycle, the rise SHALL win (load, valid=1, new_evt=1).
REQ-021 bin_value SHALL hold its value unchanged while in EMPTY after clear (valid qualifies it).
REQ-022 Latency SHALL be: a sw change held stable from sampling edge 0 updates db_sw at edge 2+DB_CYCLES and bin_value/new_evt at edge 3+DB_CYCLES.
REQ-023 Switches already high when reset releases SHALL produce an event after the REQ-022 latency (db_sw resets to 0).

Reset
REQ-024 rst_n low SHALL asynchronously force synchroniser flops, counters, db_sw, the delayed db_sw, bin_value, valid and new_evt to 0, and the FSM to EMPTY.
REQ-025 Reset asserted mid-debounce or mid-event SHALL discard all pending state; there SHALL be no event on reset release other than per REQ-023.

Structure
REQ-026 Package sw_pkg SHALL hold the PRIO_LOW/PRIO_HIGH constants and the EMPTY/HELD state encoding.
REQ-027 Sub-module sw_debounce (synchroniser + counter + db bit, one channel) SHALL be instantiated N_SW times via generate.
REQ-028 The priority encoder and FSM SHALL reside in the top module.

Verification
REQ-029 Defaults: sw=8'b0000_0100 held -> db_sw[2]=1 at edge 6, bin_value=2, valid=1, new_evt=1 for one cycle at edge 7.
REQ-030 Glitch: sw[5] high for 3 cycles then low -> db_sw unchanged, new_evt never asserted.
REQ-031 Simultaneous: sw=8'b1001_0010 in one step -> bin_value=1 (PRIO_LOW); rerun with PRIO_HIGH -> bin_value=7.
REQ-032 Clear collision: valid=1, bin_value=1; pulse clear in the same cycle as rise of sw[6] -> bin_value=6, valid=1, new_evt=1; later clear alone -> valid=0 and bin_value stays 6.
REQ-033 Reset mid-debounce: sw[3] high 2 debounce cycles, assert rst_n low -> all outputs 0 immediately; release with sw[3] still high -> event with bin_value=3 at edge 7 after release.
REQ-034 Parameter sweep: N_SW=16, DB_CYCLES=1, sw[15] rise -> bin_value=4'hF at edge 4.
